// File: rtl/axi_arbiter_w.sv
// Write-channel arbiter for a 2-master AXI interconnect: one owner holds AW/W/B from request to B response.
// Optional RESP timeout is enabled by defining AXI_ARB_W_TIMEOUT_EN.
module axi_arbiter_w #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic s_AWVALID,
  input  logic s_AWREADY,
  input  logic s_WVALID,
  input  logic s_WREADY,
  input  logic s_WLAST,
  input  logic s_BVALID,
  input  logic s_BREADY,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic busy,
  output logic timeout_err
);

  // Every channel transfers only when its VALID and READY are both high on a rising ACLK edge.
  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RESP} state_t;

  state_t state_q, state_d;
  logic   m0_grant_q, m0_grant_d;
  logic   m1_grant_q, m1_grant_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   rr_ptr_q, rr_ptr_d;
  logic   aw_hs, w_last_hs, b_hs, pick_m1;

  assign aw_hs     = s_AWVALID & s_AWREADY;
  assign w_last_hs = s_WVALID & s_WREADY & s_WLAST;
  assign b_hs      = s_BVALID & s_BREADY;
  // A lone requester wins regardless of the pointer; rr_ptr only breaks ties.
  assign pick_m1   = m1_AWVALID & (~m0_AWVALID | rr_ptr_q);

`ifdef AXI_ARB_W_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) && (CNT_W > 0);
`endif

  always_comb begin
    state_d    = state_q;
    m0_grant_d = m0_grant_q;
    m1_grant_d = m1_grant_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef AXI_ARB_W_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m0_AWVALID | m1_AWVALID) begin
          state_d    = ST_BURST;
          m0_grant_d = ~pick_m1;
          m1_grant_d = pick_m1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      ST_BURST: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d & w_done_d) begin
          state_d   = ST_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI_ARB_W_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_RESP: begin
        // The pointer moves to the master that did not own this transaction.
        if (b_hs) begin
          state_d    = ST_IDLE;
          m0_grant_d = 1'b0;
          m1_grant_d = 1'b0;
          rr_ptr_d   = m0_grant_q;
        end
`ifdef AXI_ARB_W_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          m0_grant_d    = 1'b0;
          m1_grant_d    = 1'b0;
          rr_ptr_d      = m0_grant_q;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d    = ST_IDLE;
        m0_grant_d = 1'b0;
        m1_grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      m0_grant_q <= 1'b0;
      m1_grant_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      m0_grant_q <= m0_grant_d;
      m1_grant_q <= m1_grant_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef AXI_ARB_W_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign m0_wgrnt = m0_grant_q;
  assign m1_wgrnt = m1_grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
